// File: rtl/axis_u32_to_ascii.sv
// Converts unsigned binary words to decimal ASCII bytes, most significant digit first.
// Uses a double-dabble BCD conversion, then streams the significant digits and an optional terminator.
module axis_u32_to_ascii #(
  parameter int unsigned DATA_W      = 32,
  parameter bit          APPEND_TERM = 1'b1,
  parameter logic [7:0]  TERM_CHAR   = 8'h0A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tvalid_rx,
  output logic              tready_rx,
  input  logic [DATA_W-1:0] tdata_rx,
  input  logic              tlast_rx,
  output logic              tvalid_tx,
  input  logic              tready_tx,
  output logic [7:0]        tdata_tx,
  output logic              tlast_tx
);

  localparam int unsigned DIGITS = ((DATA_W * 1233) >> 12) + 1;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned PTR_W  = $clog2(DIGITS);
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, CONVERT, ALIGN, EMIT, TERM} state_t;

  state_t             state, state_next;
  logic [DATA_W-1:0]  bin, bin_next;
  logic [BCD_W-1:0]   bcd, bcd_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [7:0]         tdata_next;
  logic               tlast_next;
  logic               tvalid_next;

  logic [BCD_W-1:0]   bcd_adj;
  logic [PTR_W-1:0]   msd;
  logic [PTR_W-1:0]   ptr_dec;
  logic [3:0]         nib;

  // Each word is its own message, so the input tlast carries no information.
  logic unused_tlast;
  assign unused_tlast = tlast_rx;

  assign tready_rx = (state == IDLE) && !rst;
  assign ptr_dec   = ptr - 1'b1;

  always_comb begin
    bcd_adj = '0;
    nib     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = bcd[4*i +: 4];
      bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  end

  // Highest non-zero digit wins; an all-zero value leaves msd at 0 so a single '0' is sent.
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = PTR_W'(i);
    end
  end

  always_comb begin
    state_next  = state;
    bin_next    = bin;
    bcd_next    = bcd;
    cnt_next    = cnt;
    ptr_next    = ptr;
    tdata_next  = tdata_tx;
    tlast_next  = tlast_tx;
    tvalid_next = tvalid_tx;
    case (state)
      IDLE: begin
        if (tvalid_rx && tready_rx) begin
          bin_next   = tdata_rx;
          bcd_next   = '0;
          cnt_next   = '0;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_next, bin_next} = {bcd_adj[BCD_W-2:0], bin, 1'b0};
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_W'(DATA_W - 1)) state_next = ALIGN;
      end
      ALIGN: begin
        ptr_next    = msd;
        tdata_next  = 8'h30 + {4'b0000, bcd[4*msd +: 4]};
        tlast_next  = (msd == '0) && !APPEND_TERM;
        tvalid_next = 1'b1;
        state_next  = EMIT;
      end
      EMIT: begin
        if (tready_tx) begin
          if (ptr != '0) begin
            ptr_next   = ptr_dec;
            tdata_next = 8'h30 + {4'b0000, bcd[4*ptr_dec +: 4]};
            tlast_next = (ptr_dec == '0) && !APPEND_TERM;
          end else if (APPEND_TERM) begin
            tdata_next = TERM_CHAR;
            tlast_next = 1'b1;
            state_next = TERM;
          end else begin
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
            state_next  = IDLE;
          end
        end
      end
      TERM: begin
        if (tready_tx) begin
          tvalid_next = 1'b0;
          tlast_next  = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      ptr       <= '0;
      tdata_tx  <= 8'h00;
      tlast_tx  <= 1'b0;
      tvalid_tx <= 1'b0;
    end else begin
      state     <= state_next;
      bin       <= bin_next;
      bcd       <= bcd_next;
      cnt       <= cnt_next;
      ptr       <= ptr_next;
      tdata_tx  <= tdata_next;
      tlast_tx  <= tlast_next;
      tvalid_tx <= tvalid_next;
    end
  end

endmodule

// File: tb/tb_axis_u32_to_ascii.sv
// Scoreboard bench for axis_u32_to_ascii: a decimal-formatting model queues expected bytes,
// and a monitor checks every output handshake, stall stability, latency and input readiness.
module tb_axis_u32_to_ascii;

  localparam int unsigned DATA_W = 32;
  localparam logic [7:0]  TERM   = 8'h0A;

  logic              clk;
  logic              rst;
  logic              tvalid_rx;
  logic              tready_rx;
  logic [DATA_W-1:0] tdata_rx;
  logic              tlast_rx;
  logic              tvalid_tx;
  logic              tready_tx;
  logic [7:0]        tdata_tx;
  logic              tlast_tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bytes_seen = 0;
  bit rand_ready = 1'b0;

  logic [8:0] exp_q[$];
  int         lat_q[$];

  axis_u32_to_ascii #(.DATA_W(DATA_W), .APPEND_TERM(1'b1), .TERM_CHAR(TERM)) dut (
    .clk(clk),
    .rst(rst),
    .tvalid_rx(tvalid_rx),
    .tready_rx(tready_rx),
    .tdata_rx(tdata_rx),
    .tlast_rx(tlast_rx),
    .tvalid_tx(tvalid_tx),
    .tready_tx(tready_tx),
    .tdata_tx(tdata_tx),
    .tlast_tx(tlast_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected message: decimal digits of the value, no leading zeros, then the terminator with tlast.
  task automatic push_expected(input logic [31:0] v);
    logic [8:0] msg[$];
    longint unsigned x;
    x = longint'(v);
    if (x == 0) msg.push_back({1'b0, 8'h30});
    while (x != 0) begin
      msg.push_front({1'b0, 8'h30 + 8'(x % 10)});
      x = x / 10;
    end
    msg.push_back({1'b1, TERM});
    foreach (msg[i]) exp_q.push_back(msg[i]);
  endtask

  task automatic apply_stimulus(input logic [31:0] v);
    bit accepted;
    accepted = 1'b0;
    tdata_rx  = v;
    tlast_rx  = 1'b1;
    tvalid_rx = 1'b1;
    for (int n = 0; n < 1000 && !accepted; n++) begin
      @(negedge clk);
      if (tready_rx) begin
        push_expected(v);
        lat_q.push_back(cyc);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    tvalid_rx = 1'b0;
    tlast_rx  = 1'b0;
    if (!accepted) check_output("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    #1;
    check_output("rst_tvalid_tx", 32'(tvalid_tx), 32'd0);
    check_output("rst_tdata_tx", 32'(tdata_tx), 32'd0);
    check_output("rst_tlast_tx", 32'(tlast_tx), 32'd0);
    check_output("rst_tready_rx", 32'(tready_rx), 32'd0);
    rst = 1'b0;
    #1;
    check_output("post_rst_tready_rx", 32'(tready_rx), 32'd1);
  endtask

  initial begin
    tready_tx = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready_tx = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: all sampling on the falling edge, where inputs and outputs are stable.
  bit         prev_valid, prev_stall, prev_hs_nolast, prev_hs_last;
  logic [9:0] prev_word;

  always @(negedge clk) begin
    logic [8:0] exp_b;
    int         acc;
    if (rst) begin
      prev_valid     = 1'b0;
      prev_stall     = 1'b0;
      prev_hs_nolast = 1'b0;
      prev_hs_last   = 1'b0;
    end else begin
      if (prev_stall)
        check_output("stall_stable", 32'({tvalid_tx, tlast_tx, tdata_tx}), 32'(prev_word));
      if (prev_hs_nolast)
        check_output("no_gap_in_message", 32'(tvalid_tx), 32'd1);
      if (prev_hs_last)
        check_output("rx_ready_after_last", 32'(tready_rx), 32'd1);
      if (tvalid_tx)
        check_output("rx_busy_while_emit", 32'(tready_rx), 32'd0);
      if (tvalid_tx && !prev_valid) begin
        if (lat_q.size() == 0) begin
          check_output("start_without_accept", 32'd1, 32'd0);
        end else begin
          acc = lat_q.pop_front();
          check_output("first_byte_latency", 32'(cyc - acc - 1), 32'(DATA_W + 1));
        end
      end
      if (tvalid_tx && tready_tx) begin
        bytes_seen++;
        if (exp_q.size() == 0) begin
          check_output("unexpected_byte", 32'({tlast_tx, tdata_tx}), 32'h1ff);
        end else begin
          exp_b = exp_q.pop_front();
          check_output("byte", 32'({tlast_tx, tdata_tx}), 32'(exp_b));
        end
      end
      prev_valid     = tvalid_tx;
      prev_stall     = tvalid_tx && !tready_tx;
      prev_hs_nolast = tvalid_tx && tready_tx && !tlast_tx;
      prev_hs_last   = tvalid_tx && tready_tx && tlast_tx;
      prev_word      = {tvalid_tx, tlast_tx, tdata_tx};
    end
  end

  initial begin
    int target;
    int budget;
    logic [31:0] v;
    rst       = 1'b1;
    tvalid_rx = 1'b0;
    tdata_rx  = '0;
    tlast_rx  = 1'b0;
    do_reset();

    apply_stimulus(32'd0);
    apply_stimulus(32'd54990);
    apply_stimulus(32'hFFFF_FFFF);
    rand_ready = 1'b1;
    apply_stimulus(32'd1000);
    apply_stimulus(32'd7);
    apply_stimulus(32'd42);
    rand_ready = 1'b0;

    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    target = bytes_seen + 2;
    apply_stimulus(32'd123456);
    budget = 0;
    while (bytes_seen < target && budget < 500) begin
      @(posedge clk);
      budget++;
    end
    if (bytes_seen < target) check_output("abort_wait_timeout", 32'(bytes_seen), 32'(target));
    do_reset();
    apply_stimulus(32'd9);

    rand_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 9);
        1: v = $urandom_range(0, 99999);
        default: v = $urandom;
      endcase
      apply_stimulus(v);
    end

    budget = 0;
    while ((exp_q.size() != 0 || tvalid_tx) && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    check_output("drain_remaining", 32'(exp_q.size()), 32'd0);
    repeat (5) @(posedge clk);
    check_output("latency_queue_empty", 32'(lat_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
